// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode sequencer for an RV32I subset (ADDI/ADD/BEQ/BNE).
// Three cycles per instruction: FETCH -> DECODE -> EXEC; HALT is absorbing.
module fetch_decode_ctrl #(
    parameter int DATA_WIDTH          = 32,
    parameter int REG_FILE_ADDR_WIDTH = 5,
    parameter int PC_WIDTH            = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           run,
    output logic [PC_WIDTH-1:0]            instr_addr,
    input  logic [31:0]                    instr_data,
    input  logic                           EQ,
    output logic [REG_FILE_ADDR_WIDTH-1:0] AD1,
    output logic [REG_FILE_ADDR_WIDTH-1:0] AD2,
    output logic [REG_FILE_ADDR_WIDTH-1:0] AD3,
    output logic                           WE3,
    output logic                           ALUsrc,
    output logic                           ALUctrl,
    output logic [DATA_WIDTH-1:0]          ImmOp,
    output logic [PC_WIDTH-1:0]            pc,
    output logic                           retire,
    output logic                           halted
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   w_pc_next;
    logic [PC_WIDTH-1:0]   w_target;
    logic [PC_WIDTH-1:0]   w_br_off;
    logic [31:0]           r_ir;
    logic                  r_halted;
    logic                  w_halted_next;
    logic                  w_ir_load;
    logic                  w_is_addi;
    logic                  w_is_add;
    logic                  w_is_beq;
    logic                  w_is_bne;
    logic                  w_is_br;
    logic                  w_taken;
    logic                  w_rd_nz;
    logic [DATA_WIDTH-1:0] w_imm_i;
    logic [DATA_WIDTH-1:0] w_imm_b;

    function automatic logic f_legal(input logic [31:0] w);
        logic ok;
        ok = 1'b0;
        if (w[6:0] == 7'b0010011 && w[14:12] == 3'b000)
            ok = 1'b1;
        if (w[6:0] == 7'b0110011 && w[14:12] == 3'b000 && w[31:25] == 7'b0)
            ok = 1'b1;
        if (w[6:0] == 7'b1100011 && w[14:13] == 2'b00)
            ok = 1'b1;
        return ok;
    endfunction

    assign w_is_addi = (r_ir[6:0] == 7'b0010011) && (r_ir[14:12] == 3'b000);
    assign w_is_add  = (r_ir[6:0] == 7'b0110011) && (r_ir[14:12] == 3'b000)
                     && (r_ir[31:25] == 7'b0);
    assign w_is_beq  = (r_ir[6:0] == 7'b1100011) && (r_ir[14:12] == 3'b000);
    assign w_is_bne  = (r_ir[6:0] == 7'b1100011) && (r_ir[14:12] == 3'b001);
    assign w_is_br   = w_is_beq | w_is_bne;
    assign w_rd_nz   = (r_ir[11:7] != 5'd0);

    assign w_imm_i  = {{(DATA_WIDTH-12){r_ir[31]}}, r_ir[31:20]};
    assign w_imm_b  = {{(DATA_WIDTH-13){r_ir[31]}}, r_ir[31], r_ir[7],
                       r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_br_off = {{(PC_WIDTH-13){r_ir[31]}}, r_ir[31], r_ir[7],
                       r_ir[30:25], r_ir[11:8], 1'b0};

    assign w_taken  = (w_is_beq & EQ) | (w_is_bne & ~EQ);
    assign w_target = w_taken ? (r_pc + w_br_off) : (r_pc + PC_WIDTH'(4));

    assign instr_addr = r_pc;
    assign pc         = r_pc;
    assign halted     = r_halted;
    assign AD1        = REG_FILE_ADDR_WIDTH'(r_ir[19:15]);
    assign AD2        = REG_FILE_ADDR_WIDTH'(r_ir[24:20]);
    assign AD3        = w_is_br ? '0 : REG_FILE_ADDR_WIDTH'(r_ir[11:7]);

    always_comb begin
        w_next        = r_state;
        w_pc_next     = r_pc;
        w_halted_next = r_halted;
        w_ir_load     = 1'b0;
        WE3           = 1'b0;
        ALUsrc        = 1'b0;
        ALUctrl       = 1'b0;
        ImmOp         = '0;
        retire        = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                if (run)
                    w_next = S_DECODE;
            end
            S_DECODE: begin
                w_ir_load = 1'b1;
                if (f_legal(instr_data)) begin
                    w_next = S_EXEC;
                end else begin
                    w_next        = S_HALT;
                    w_halted_next = 1'b1;
                end
            end
            S_EXEC: begin
                // a reset landing on EXEC abandons the instruction: no write
                if (w_is_addi) begin
                    ALUsrc = 1'b1;
                    ImmOp  = w_imm_i;
                    WE3    = w_rd_nz & rst_n;
                end else if (w_is_add) begin
                    WE3 = w_rd_nz & rst_n;
                end else begin
                    ALUctrl = 1'b1;
                    ImmOp   = w_imm_b;
                end
                if (w_target[1]) begin
                    w_next        = S_HALT;
                    w_halted_next = 1'b1;
                end else begin
                    w_next    = S_FETCH;
                    w_pc_next = w_target;
                    retire    = rst_n;
                end
            end
            S_HALT: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_pc     <= w_pc_next;
            r_halted <= w_halted_next;
            if (w_ir_load)
                r_ir <= instr_data;
        end
    end

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Bench for fetch_decode_ctrl: directed scenarios plus random programs,
// checked every cycle against an instruction-level reference model.
module tb_fetch_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        EQ = 1'b0;
    logic [31:0] instr_addr;
    logic [31:0] instr_data = '0;
    logic [4:0]  AD1, AD2, AD3;
    logic        WE3, ALUsrc, ALUctrl, retire, halted;
    logic [31:0] ImmOp, pc;

    logic [31:0] rom [64];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int          m_phase = 0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_ir = '0;
    bit          m_halt = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) instr_data <= rom[instr_addr[7:2]];

    fetch_decode_ctrl dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .instr_addr(instr_addr), .instr_data(instr_data), .EQ(EQ),
        .AD1(AD1), .AD2(AD2), .AD3(AD3),
        .WE3(WE3), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .ImmOp(ImmOp),
        .pc(pc), .retire(retire), .halted(halted)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_addi(input logic [31:0] w);
        return w[6:0] == 7'h13 && w[14:12] == 3'd0;
    endfunction
    function automatic bit is_add(input logic [31:0] w);
        return w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'd0;
    endfunction
    function automatic bit is_beq(input logic [31:0] w);
        return w[6:0] == 7'h63 && w[14:12] == 3'd0;
    endfunction
    function automatic bit is_bne(input logic [31:0] w);
        return w[6:0] == 7'h63 && w[14:12] == 3'd1;
    endfunction
    function automatic logic [31:0] imm_i(input logic [31:0] w);
        return {{20{w[31]}}, w[31:20]};
    endfunction
    function automatic logic [31:0] imm_b(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] gen_instr();
        int          k;
        int          off;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] i12;
        logic [12:0] b;
        logic [31:0] tmp;
        k   = int'($urandom % 20);
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        i12 = 12'($urandom);
        off = (int'($urandom_range(32, 0)) - 16) * 4;
        if ($urandom % 16 == 0) off += 2;
        tmp = off;
        b   = tmp[12:0];
        if (k == 0) begin
            tmp = $urandom;
            return {tmp[31:7], 7'h7F};
        end
        if (k == 1) return {7'b0100000, rs2, rs1, 3'd0, rd, 7'h33};
        if (k < 8)  return {i12, rs1, 3'd0, rd, 7'h13};
        if (k < 12) return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
        return {b[12], b[10:5], rs2, rs1, 2'b00, k[0], b[4:1], b[11], 7'h63};
    endfunction

    // one clock: drive at negedge, compare outputs, advance the model at posedge
    task automatic cyc(input bit r, input bit run_i, input bit eq_i);
        logic [31:0] ir, tgt, e_imm, w;
        bit          ex, br, taken;
        @(negedge clk);
        rst_n = r;
        run   = run_i;
        EQ    = eq_i;
        #1;
        ir    = m_ir;
        ex    = (m_phase == 2) && !m_halt;
        br    = is_beq(ir) || is_bne(ir);
        taken = (is_beq(ir) && eq_i) || (is_bne(ir) && !eq_i);
        tgt   = taken ? m_pc + imm_b(ir) : m_pc + 32'd4;
        e_imm = !ex ? 32'd0 : is_addi(ir) ? imm_i(ir) : br ? imm_b(ir) : 32'd0;
        check("pc", pc, m_pc);
        check("instr_addr", instr_addr, m_pc);
        check("halted", 32'(halted), 32'(m_halt));
        check("AD1", 32'(AD1), 32'(ir[19:15]));
        check("AD2", 32'(AD2), 32'(ir[24:20]));
        check("AD3", 32'(AD3), br ? 32'd0 : 32'(ir[11:7]));
        check("WE3", 32'(WE3),
              32'(ex && r && (is_addi(ir) || is_add(ir)) && ir[11:7] != 0));
        check("ALUsrc", 32'(ALUsrc), 32'(ex && is_addi(ir)));
        check("ALUctrl", 32'(ALUctrl), 32'(ex && br));
        check("ImmOp", ImmOp, e_imm);
        check("retire", 32'(retire), 32'(ex && r && !tgt[1]));
        @(posedge clk);
        if (!r) begin
            m_phase = 0;
            m_pc    = '0;
            m_ir    = '0;
            m_halt  = 1'b0;
        end else if (!m_halt) begin
            if (m_phase == 0) begin
                if (run_i) m_phase = 1;
            end else if (m_phase == 1) begin
                w    = rom[m_pc[7:2]];
                m_ir = w;
                if (is_addi(w) || is_add(w) || is_beq(w) || is_bne(w))
                    m_phase = 2;
                else
                    m_halt = 1'b1;
            end else begin
                if (tgt[1]) begin
                    m_halt = 1'b1;
                end else begin
                    m_pc    = tgt;
                    m_phase = 0;
                end
            end
        end
    endtask

    task automatic run_n(input int n, input bit eq_i);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, eq_i);
    endtask

    initial begin
        bit r, ru, eq;
        for (int i = 0; i < 64; i++) rom[i] = 32'd0;
        rom[0] = 32'h00500513;
        rom[1] = 32'hFFF00513;
        rom[2] = 32'hFE051EE3;
        rom[3] = 32'h00208033;
        rom[4] = 32'h00000000;

        // reset, then reset again in the middle of an ADDI's EXEC
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        run_n(2, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        #2;
        check("rst_pc", pc, 32'd0);
        check("rst_addr", instr_addr, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_we3", 32'(WE3), 32'd0);

        // ADDI x10,x0,5
        run_n(2, 1'b0);
        #2;
        check("addi_imm", ImmOp, 32'd5);
        check("addi_ad3", 32'(AD3), 32'd10);
        check("addi_we3", 32'(WE3), 32'd1);
        check("addi_src", 32'(ALUsrc), 32'd1);
        run_n(1, 1'b0);
        #2;
        check("addi_pc", pc, 32'd4);

        // ADDI x10,x0,-1
        run_n(2, 1'b0);
        #2;
        check("addi_neg_imm", ImmOp, 32'hFFFFFFFF);
        run_n(1, 1'b0);

        // BNE at 8, EQ=0 taken back to 4
        run_n(2, 1'b0);
        #2;
        check("bne_ctl", 32'(ALUctrl), 32'd1);
        check("bne_we3", 32'(WE3), 32'd0);
        run_n(1, 1'b0);
        #2;
        check("bne_taken_pc", pc, 32'd4);

        // ADDI at 4, then BNE with EQ=1 falls through to 12
        run_n(3, 1'b1);
        run_n(3, 1'b1);
        #2;
        check("bne_nt_pc", pc, 32'd12);

        // ADD x0,x1,x2 never writes
        run_n(2, 1'b0);
        #2;
        check("add_x0_we3", 32'(WE3), 32'd0);
        run_n(1, 1'b0);

        // illegal word at 16 halts and stays halted
        run_n(2, 1'b0);
        #2;
        check("ill_halted", 32'(halted), 32'd1);
        run_n(5, 1'b1);
        #2;
        check("ill_pc_held", pc, 32'd16);
        check("ill_still_halted", 32'(halted), 32'd1);

        // run dropped mid-instruction: retire, then stall in FETCH
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
        #2;
        check("stall_pc", pc, 32'd4);
        check("stall_addr", instr_addr, 32'd4);
        run_n(3, 1'b0);
        #2;
        check("resume_pc", pc, 32'd8);

        // BEQ x0,x0,-4 at 0 wraps to 0xFFFFFFFC, ADDI there wraps to 0
        cyc(1'b0, 1'b0, 1'b0);
        rom[0]  = 32'hFE000EE3;
        rom[63] = 32'h00500513;
        cyc(1'b0, 1'b0, 1'b0);
        run_n(3, 1'b1);
        #2;
        check("wrap_back_pc", pc, 32'hFFFFFFFC);
        run_n(3, 1'b1);
        #2;
        check("wrap_fwd_pc", pc, 32'd0);

        // taken branch to a misaligned target halts with pc unchanged
        cyc(1'b0, 1'b0, 1'b0);
        rom[0] = 32'h00000163;
        cyc(1'b0, 1'b0, 1'b0);
        run_n(3, 1'b1);
        #2;
        check("misalign_halted", 32'(halted), 32'd1);
        check("misalign_pc", pc, 32'd0);

        // random programs, random run/EQ, occasional reset
        for (int i = 0; i < 64; i++) rom[i] = gen_instr();
        cyc(1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            r  = m_halt ? ($urandom % 8 != 0) : ($urandom % 300 != 0);
            ru = ($urandom % 5 != 0);
            eq = 1'($urandom);
            if (!r)
                for (int i = 0; i < 64; i++) rom[i] = gen_instr();
            cyc(r, ru, eq);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
